angle_rate_estimator: RTL
=========================

Name: angle_rate_estimator

Overview:
- Inverse companion to the attitude integrator: takes a stream of signed angle samples and recovers angular rate as the averaged per-sample difference.
- Consumes angle samples through a valid strobe, typically one per sample tick. Produces a saturated signed rate with a one-cycle valid pulse and an 8-bit LED view.
- Used for closed-loop checking of the integrator. Will later sit behind a sensor front end.

Parameters:
- ANGLE_W, 16: angle sample width, signed two's complement, wraps modulo 2^ANGLE_W.
- RATE_W, 8: output rate width, signed; must be >= 8.
- AVG_LOG2, 2: log2 of averaging window depth (window = 4 diffs). Legal range 0..4.

Ports:
- clk  in  1  system clock.
- reset_p  in  1  reset.
- clear  in  1  synchronous flush of estimator state.
- angle_in  in  ANGLE_W  signed angle sample.
- angle_valid  in  1  angle_in is valid this cycle; accepted every cycle, no backpressure.
- rate_out  out  RATE_W  signed averaged rate, in angle LSBs per sample.
- rate_valid  out  1  one-cycle pulse when rate_out updates.
- saturated  out  1  registered with rate_out; 1 if the current rate_out was clamped.
- led  out  8  rate_out[RATE_W-1 -: 8].

Behaviour:
- Reset and clock: reset reset_p, asynchronous, active-high; clock clk.
- Reset values: rate_out=0, rate_valid=0, saturated=0, led=0. State IDLE; window buffer, running sum, prev and fill count all 0.
- State machine:
  - IDLE: no previous sample held. An accepted sample stores prev=angle_in, moves to FILL with fill_cnt=0, and produces no output.
  - FILL: each accepted sample pushes a diff and increments fill_cnt. The sample that makes 2^AVG_LOG2 diffs moves to RUN and produces the first output.
  - RUN: every accepted sample pushes a diff and produces an output.
- Diff: diff = angle_in - prev, computed modulo 2^ANGLE_W and interpreted as ANGLE_W-bit signed. A wrap from 0x7FFF to 0x8000 is therefore +1. prev <= angle_in on every accepted sample.
- Window: circular buffer of 2^AVG_LOG2 diffs. Write pointer wraps; the oldest entry is overwritten.
  - Running sum, ANGLE_W+AVG_LOG2 bits signed: sum <= sum + diff - oldest.
  - Entries start at 0, so no special case applies during FILL.
- Pipeline, fixed 2-cycle latency:
  - Edge k: angle_valid sampled high; diff, sum and buffer update.
  - Edge k+1: avg = sum >>> AVG_LOG2 (arithmetic, rounds toward -inf). avg is clamped to [-2^(RATE_W-1), 2^(RATE_W-1)-1]; rate_out, saturated and led are registered; rate_valid=1 for one cycle.
- Throughput: angle_valid may be high every cycle; one output per accepted sample in RUN.
- Between outputs, rate_out and saturated hold their last values; rate_valid=0.
- clear, synchronous: same effect as reset on all state and outputs, and any result in flight is discarded.
  - clear and angle_valid in the same cycle: clear wins and the sample is dropped.
  - The first sample after clear re-primes from IDLE.
- Reset mid-operation: immediate return to reset values; no partial output is emitted afterwards.

Decomposition:
- Shared package: state enum (IDLE, FILL, RUN); default width constants ANGLE_W_DEF=16 and RATE_W_DEF=8; a saturate-to-signed function.
- One sub-module: diff_window. Holds the circular buffer, write pointer and running sum; ports are push, diff, flush and sum. The top level keeps the FSM, prev, and the output and saturation stage.

Test Plan:
- Ramp up: after reset, angle_valid every cycle with angle 0,1,2,...,9.
  - No rate_valid for samples 0..3.
  - Sample 4 gives rate_out=1 two edges later, then 1 on every following sample; saturated=0; led=0x01.
- Ramp down: angle 0,-1,-2,...,-8, as the integrator produces with a rate of -1, one sample per 4 cycles.
  - rate_out=-1 (0xFF) after sample 4, with a one-pulse rate_valid per sample.
- Wrap: angle 0x7FFE, 0x7FFF, 0x8000, 0x8001, 0x8002 -> rate_out=+1, saturated=0 (not -65535 or a clamp).
- Saturation:
  - Angles 0,200,400,600,800 -> rate_out=127, saturated=1.
  - Angles 0,-300,-600,-900,-1200 -> rate_out=-128, saturated=1.
- Rounding: diffs 1,1,1,2 -> rate_out=1; diffs -1,-1,-1,-2 -> rate_out=-2.
- Flush and reset:
  - clear asserted during FILL, and again together with angle_valid: outputs go to 0, the concurrent sample is dropped, and the next 5 samples are required before rate_valid.
  - reset_p pulsed mid-RUN between pipeline edges: no rate_valid follows, and all outputs are 0.

Source files
------------

// File: rtl/angle_rate_estimator_pkg.sv
// angle_rate_estimator_pkg
//   Shared types and helpers for the angle rate estimator.
//   - state_e          : estimator sequencing state (IDLE / FILL / RUN)
//   - *_DEF            : default widths used by the top and sub-module
//   - saturate_signed  : clamps a 32-bit signed value into a signed field
//                        of the given width (width must be 2..31)
package angle_rate_estimator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no previous sample held
    ST_FILL = 2'd1,  // window not yet full, no outputs
    ST_RUN  = 2'd2   // one output per accepted sample
  } state_e;

  localparam int ANGLE_W_DEF  = 16;
  localparam int RATE_W_DEF   = 8;
  localparam int AVG_LOG2_DEF = 2;

  // Clamp value into [-2^(width-1), 2^(width-1)-1]. The caller detects a
  // clamp by comparing the result against the input.
  function automatic logic signed [31:0] saturate_signed(
    input logic signed [31:0] value,
    input int                 width
  );
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
    min_v = -(32'sd1 <<< (width - 1));
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

endpackage

// File: rtl/angle_rate_estimator_diff_window.sv
// angle_rate_estimator_diff_window
//   Circular buffer of the last 2^AVG_LOG2 angle differences together with
//   their running sum. Each push overwrites the oldest entry and updates the
//   sum by (new - oldest), so the sum is always the sum of the buffer.
// Ports:
//   clk, reset_p : clock, asynchronous active-high reset
//   push         : write diff into the window this cycle
//   diff         : signed angle difference to push
//   flush        : synchronous clear of buffer, pointer and sum (wins over push)
//   sum          : signed running sum of all window entries
module angle_rate_estimator_diff_window
  import angle_rate_estimator_pkg::*;
#(
  parameter int ANGLE_W  = ANGLE_W_DEF,
  parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
  input  logic                                clk,
  input  logic                                reset_p,
  input  logic                                push,
  input  logic signed [ANGLE_W-1:0]           diff,
  input  logic                                flush,
  output logic signed [ANGLE_W+AVG_LOG2-1:0]  sum
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SUM_W = ANGLE_W + AVG_LOG2;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic signed [ANGLE_W-1:0] buf_q [DEPTH];
  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic signed [SUM_W-1:0]   sum_q, sum_d;
  logic signed [ANGLE_W-1:0] oldest;
  logic signed [SUM_W-1:0]   diff_ext;
  logic signed [SUM_W-1:0]   oldest_ext;

  assign oldest     = buf_q[ptr_q];
  assign diff_ext   = SUM_W'(diff);
  assign oldest_ext = SUM_W'(oldest);

  // NOTE: every variable assigned in always_comb gets a default first, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    ptr_d = ptr_q;
    sum_d = sum_q;
    if (flush) begin
      ptr_d = '0;
      sum_d = '0;
    end else if (push) begin
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
      sum_d = sum_q + diff_ext - oldest_ext;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      ptr_q <= '0;
      sum_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      sum_q <= sum_d;
    end
  end

  // NOTE: the buffer is reset and flushed explicitly because the running sum
  // relies on every entry starting at zero; an unreset RAM would corrupt it.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else if (push) begin
      buf_q[ptr_q] <= diff;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/angle_rate_estimator.sv
// angle_rate_estimator
//   Recovers angular rate from a stream of wrapping signed angle samples as
//   the average of the last 2^AVG_LOG2 per-sample differences. The result is
//   saturated to RATE_W bits and emitted two edges after the sample that
//   completes it, with a one-cycle rate_valid pulse.
// Ports:
//   clk, reset_p : clock, asynchronous active-high reset
//   clear        : synchronous flush of all state and outputs (wins over data)
//   angle_in     : signed angle sample, wraps modulo 2^ANGLE_W
//   angle_valid  : angle_in accepted this cycle (no backpressure)
//   rate_out     : signed averaged rate, angle LSBs per sample
//   rate_valid   : one-cycle pulse when rate_out updates
//   saturated    : rate_out was clamped
//   led          : top 8 bits of rate_out
module angle_rate_estimator
  import angle_rate_estimator_pkg::*;
#(
  parameter int ANGLE_W  = ANGLE_W_DEF,
  parameter int RATE_W   = RATE_W_DEF,
  parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
  input  logic                clk,
  input  logic                reset_p,
  input  logic                clear,
  input  logic [ANGLE_W-1:0]  angle_in,
  input  logic                angle_valid,
  output logic [RATE_W-1:0]   rate_out,
  output logic                rate_valid,
  output logic                saturated,
  output logic [7:0]          led
);

  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int SUM_W  = ANGLE_W + AVG_LOG2;
  localparam int FILL_W = AVG_LOG2 + 1;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(DEPTH - 1);

  state_e                    state_q, state_d;
  logic [ANGLE_W-1:0]        prev_q;
  logic [FILL_W-1:0]         fill_cnt_q, fill_cnt_d;
  logic                      accept;
  logic                      push;
  logic                      emit;
  logic signed [ANGLE_W-1:0] diff;
  logic signed [SUM_W-1:0]   sum;
  logic signed [SUM_W-1:0]   avg;
  logic signed [31:0]        avg_ext;
  logic signed [31:0]        sat_val;
  logic                      pending_q;
  logic [RATE_W-1:0]         rate_q;
  logic                      sat_q;
  logic                      rate_valid_q;

  // clear overrides a concurrent sample.
  assign accept = angle_valid && !clear;

  // Modulo subtraction: a wrap from max positive to max negative reads as +1.
  assign diff = angle_in - prev_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q    <= ST_IDLE;
      prev_q     <= '0;
      fill_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= clear ? '0 : (accept ? angle_in : prev_q);
      fill_cnt_q <= fill_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else if (accept) begin
      case (state_q)
        ST_IDLE: state_d = ST_FILL;
        ST_FILL: state_d = (fill_cnt_q == FILL_LAST) ? ST_RUN : ST_FILL;
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    push       = 1'b0;
    emit       = 1'b0;
    fill_cnt_d = fill_cnt_q;
    if (clear) begin
      fill_cnt_d = '0;
    end else if (accept) begin
      case (state_q)
        ST_IDLE: fill_cnt_d = '0;
        ST_FILL: begin
          push       = 1'b1;
          emit       = (fill_cnt_q == FILL_LAST);
          fill_cnt_d = fill_cnt_q + 1'b1;
        end
        ST_RUN: begin
          push = 1'b1;
          emit = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------ window and sum
  angle_rate_estimator_diff_window #(
    .ANGLE_W  (ANGLE_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_diff_window (
    .clk     (clk),
    .reset_p (reset_p),
    .push    (push),
    .diff    (diff),
    .flush   (clear),
    .sum     (sum)
  );

  // ----------------------------------------------- average and saturate
  // Arithmetic shift rounds toward -inf.
  assign avg     = sum >>> AVG_LOG2;
  assign avg_ext = 32'(avg);
  assign sat_val = saturate_signed(avg_ext, RATE_W);

  // pending_q marks the sum registered at edge k as due for output at k+1.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      pending_q    <= 1'b0;
      rate_valid_q <= 1'b0;
      rate_q       <= '0;
      sat_q        <= 1'b0;
    end else if (clear) begin
      pending_q    <= 1'b0;
      rate_valid_q <= 1'b0;
      rate_q       <= '0;
      sat_q        <= 1'b0;
    end else begin
      pending_q    <= emit;
      rate_valid_q <= pending_q;
      if (pending_q) begin
        rate_q <= RATE_W'(sat_val);
        sat_q  <= (sat_val != avg_ext);
      end
    end
  end

  assign rate_out   = rate_q;
  assign rate_valid = rate_valid_q;
  assign saturated  = sat_q;
  assign led        = rate_q[RATE_W-1 -: 8];

endmodule
